// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the 2-read/1-write data memory.
// Optional parity storage is enabled by DATA_MEM_2R1W_PARITY_EN.
package data_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } dm_state_t;

  // Widest word even_parity() accepts; narrower words are zero-extended.
  localparam int PAR_MAX_W = 256;

  // Even parity bit: makes the total number of ones (data + bit) even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage : data_mem_pkg

// File: rtl/data_mem_rd_port.sv
// One registered read port: range check, write-first forwarding, output register.
// Parity checking of the stored word is added when DATA_MEM_2R1W_PARITY_EN is defined.
module data_mem_rd_port
  import data_mem_pkg::*;
#(
  parameter int W     = 8,
  parameter int A     = 8,
  parameter int DEPTH = 2**A,
  parameter int MW    = W
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          i_clear,
  input  logic [A-1:0]  i_rd_addr,
  input  logic [MW-1:0] i_mem_word,
  input  logic          i_wr_en,
  input  logic [A-1:0]  i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
`ifdef DATA_MEM_2R1W_PARITY_EN
  output logic          o_par_err,
`endif
  output logic [W-1:0]  o_rd_data
);

  localparam logic [A:0] DEPTH_X = (A+1)'(DEPTH);

  logic         w_in_range;
  logic         w_fwd;
  logic [W-1:0] w_data_nxt;
  logic [W-1:0] r_rd_data;
`ifdef DATA_MEM_2R1W_PARITY_EN
  logic         w_perr_nxt;
  logic         r_par_err;
`endif

  assign w_in_range = ({1'b0, i_rd_addr} < DEPTH_X);
  assign w_fwd      = i_wr_en && (i_wr_addr == i_rd_addr);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    w_data_nxt = '0;
`ifdef DATA_MEM_2R1W_PARITY_EN
    w_perr_nxt = 1'b0;
`endif
    if (!i_clear && w_in_range) begin
      if (w_fwd) begin
        w_data_nxt = i_wr_data;
      end else begin
        w_data_nxt = i_mem_word[W-1:0];
`ifdef DATA_MEM_2R1W_PARITY_EN
        w_perr_nxt = (even_parity(PAR_MAX_W'(i_mem_word[W-1:0])) != i_mem_word[MW-1]);
`endif
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_rd_data <= '0;
`ifdef DATA_MEM_2R1W_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else begin
      r_rd_data <= w_data_nxt;
`ifdef DATA_MEM_2R1W_PARITY_EN
      r_par_err <= w_perr_nxt;
`endif
    end
  end

  assign o_rd_data = r_rd_data;
`ifdef DATA_MEM_2R1W_PARITY_EN
  assign o_par_err = r_par_err;
`endif

endmodule : data_mem_rd_port

// File: rtl/data_mem_2r1w.sv
// Data memory with one write port, two registered read ports and a clear sweep after reset.
// Define DATA_MEM_2R1W_PARITY_EN to store a per-word even-parity bit and report read errors.
module data_mem_2r1w
  import data_mem_pkg::*;
#(
  parameter int W     = 8,
  parameter int A     = 8,
  parameter int DEPTH = 2**A
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         WriteEn,
  input  logic [A-1:0] WrAddress,
  input  logic [W-1:0] DataIn,
  input  logic [A-1:0] RdAddrA,
  output logic [W-1:0] RdDataA,
  input  logic [A-1:0] RdAddrB,
  output logic [W-1:0] RdDataB,
`ifdef DATA_MEM_2R1W_PARITY_EN
  input  logic         ErrInject,
  output logic         ParErrA,
  output logic         ParErrB,
`endif
  output logic         Busy
);

  if (DEPTH < 1 || DEPTH > 2**A) begin : g_bad_depth
    $error("data_mem_2r1w: DEPTH must be in 1..2**A");
  end

`ifdef DATA_MEM_2R1W_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int           MW       = W + PB;
  localparam logic [A:0]   DEPTH_X  = (A+1)'(DEPTH);
  localparam logic [A-1:0] LAST_PTR = A'(DEPTH - 1);

  dm_state_t     r_state;
  dm_state_t     w_state_nxt;
  logic [A-1:0]  r_clr_ptr;
  logic [A-1:0]  w_clr_ptr_nxt;
  logic          w_clear;
  logic          w_wr_in_range;
  logic          w_mem_we;
  logic [A-1:0]  w_mem_waddr;
  logic [MW-1:0] w_wr_word;
  logic [MW-1:0] w_mem_wdata;
  logic [MW-1:0] w_rd_word_a;
  logic [MW-1:0] w_rd_word_b;

  logic [MW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    case (r_state)
      CLEAR: begin
        w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        if (r_clr_ptr == LAST_PTR) w_state_nxt = IDLE;
      end
      IDLE:    w_state_nxt = IDLE;
      default: w_state_nxt = CLEAR;
    endcase
  end

  assign w_clear       = (r_state == CLEAR);
  assign Busy          = w_clear;
  assign w_wr_in_range = ({1'b0, WrAddress} < DEPTH_X);

`ifdef DATA_MEM_2R1W_PARITY_EN
  assign w_wr_word = {even_parity(PAR_MAX_W'(DataIn)) ^ ErrInject, DataIn};
`else
  assign w_wr_word = DataIn;
`endif

  // The sweep owns the write port while clearing; user writes are dropped, not queued.
  assign w_mem_we    = !Reset && (w_clear || (WriteEn && w_wr_in_range));
  assign w_mem_waddr = w_clear ? r_clr_ptr : WrAddress;
  assign w_mem_wdata = w_clear ? '0 : w_wr_word;

  // NOTE: the array has no reset branch; it is cleared by the sweep, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  assign w_rd_word_a = r_mem[RdAddrA];
  assign w_rd_word_b = r_mem[RdAddrB];

  data_mem_rd_port #(.W(W), .A(A), .DEPTH(DEPTH), .MW(MW)) u_rd_a (
    .clk        (clk),
    .Reset      (Reset),
    .i_clear    (w_clear),
    .i_rd_addr  (RdAddrA),
    .i_mem_word (w_rd_word_a),
    .i_wr_en    (WriteEn),
    .i_wr_addr  (WrAddress),
    .i_wr_data  (DataIn),
`ifdef DATA_MEM_2R1W_PARITY_EN
    .o_par_err  (ParErrA),
`endif
    .o_rd_data  (RdDataA)
  );

  data_mem_rd_port #(.W(W), .A(A), .DEPTH(DEPTH), .MW(MW)) u_rd_b (
    .clk        (clk),
    .Reset      (Reset),
    .i_clear    (w_clear),
    .i_rd_addr  (RdAddrB),
    .i_mem_word (w_rd_word_b),
    .i_wr_en    (WriteEn),
    .i_wr_addr  (WrAddress),
    .i_wr_data  (DataIn),
`ifdef DATA_MEM_2R1W_PARITY_EN
    .o_par_err  (ParErrB),
`endif
    .o_rd_data  (RdDataB)
  );

endmodule : data_mem_2r1w

// File: doc/data_mem_2r1w.md
Name: data_mem_2r1w

Overview:
- Next-generation data memory: parametrised width, address width and depth.
- One synchronous write port, two independent registered read ports.
- Self-clearing sweep on reset and write-first forwarding.
- Sits in the datapath in place of the single-port data memory; the second read port serves the pipeline or debug readout without stalling loads.

Parameters:
- W, 8, data word width in bits.
- A, 8, address width in bits.
- DEPTH, 2**A, number of implemented words; must satisfy 1 <= DEPTH <= 2**A.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- WriteEn  input  1  write strobe.
- WrAddress  input  A  write address.
- DataIn  input  W  write data.
- RdAddrA  input  A  read port A address.
- RdDataA  output  W  read port A data, registered.
- RdAddrB  input  A  read port B address.
- RdDataB  output  W  read port B data, registered.
- Busy  output  1  high while the clear sweep is in progress.

Behaviour:
- Interface: one clock (clk); reset (Reset) is synchronous and active-high.
- FSM states:
  - CLEAR: sweep writes zeros.
  - IDLE: normal operation.
- Clear pointer clr_ptr: A bits.
- Any edge with Reset=1:
  - state<=CLEAR, clr_ptr<=0.
  - RdDataA<=0, RdDataB<=0, Busy<=1.
  - No memory write.
- CLEAR with Reset=0, each edge:
  - mem[clr_ptr]<=0, clr_ptr<=clr_ptr+1.
  - When clr_ptr==DEPTH-1: write, then state<=IDLE, Busy<=0.
  - Busy is therefore high for exactly DEPTH edges after Reset release.
- During CLEAR:
  - WriteEn is ignored; the write is dropped, not queued.
  - RdDataA and RdDataB load 0.
- Reset asserted mid-sweep restarts the sweep at address 0.
- IDLE write: if WriteEn=1 and WrAddress<DEPTH, mem[WrAddress]<=DataIn at the edge.
- Out-of-range writes (WrAddress>=DEPTH) are silently dropped.
- IDLE read, per port X: RdDataX <= value at RdAddrX, with 1-cycle latency. The value is:
  - 0 if RdAddrX>=DEPTH.
  - else DataIn if WriteEn=1 and WrAddress==RdAddrX (write-first forwarding).
  - else mem[RdAddrX].
- Both ports may read the same address in the same cycle; both get identical data.
- RdData holds its last value only if the address is unchanged and no write hits it, since reads are re-evaluated every edge.
- Memory contents persist across IDLE cycles.
- Memory has no reset other than the sweep.

Optional Feature:
- Macro: DATA_MEM_2R1W_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed from DataIn on write; the clear sweep stores parity 0.
  - Added ports:
    - input ErrInject (1): when high during a write, the stored parity bit is inverted.
    - outputs ParErrA, ParErrB (1 each, registered alongside RdData): high when the read word's recomputed parity mismatches the stored bit.
  - Forwarded reads and out-of-range reads report ParErr=0.
  - Reset clears ParErrA and ParErrB to 0.
- Undefined: no parity storage, no extra ports.

Decomposition:
- Package data_mem_pkg:
  - typedef enum {CLEAR, IDLE} dm_state_t.
  - Function even_parity(word).
- One natural sub-module: data_mem_rd_port, instantiated twice. It contains the range check, forwarding mux and output register, plus parity check when enabled.

Test Plan:
- Reset 1 cycle, W=8, A=8, DEPTH=256 -> Busy=1 for exactly 256 edges after release, then 0; read addr 0x37 returns 0x00.
- After clear, write mem[i]=i^0xAA for all i, then read port A ascending and port B descending -> A returns i^0xAA one cycle after the address; B independently correct.
- WriteEn=1, WrAddress=0x10, DataIn=0x5C, RdAddrA=0x10 same cycle -> RdDataA=0x5C next cycle (forwarded); RdDataB reading 0x11 is unaffected.
- Writes with WriteEn=1 during the sweep (addr 0x80, data 0xFF) -> after Busy falls, mem[0x80] reads 0x00.
- Reset re-asserted at sweep cycle 100 -> Busy stays high a further 256 edges after second release; previously written data at 0xF0 reads 0x00.
- DEPTH=200: write 0x77 to 0xC8, read 0xC8 -> RdData=0x00; write/read 0xC7 -> 0x77. With PARITY_EN: write 0x03 with ErrInject=1 -> ParErrA=1 on read; without inject -> 0.
